// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single-outstanding imem handshake, IF/ID register.
// Holds a one-entry skid for words returning while decode is stalled.
module instruction_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imemReq,
  output logic [XLEN-1:0] imemAddr,
  input  logic            imemReady,
  input  logic            imemRvalid,
  input  logic [31:0]     imemRdata,
  input  logic            PCSource,
  input  logic [XLEN-1:0] PCTarget,
  input  logic            stall,
  input  logic            flush,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instrPC,
  output logic [XLEN-1:0] instrPCPlus4,
  output logic            instrValid,
  output logic [6:0]      OPCode,
  output logic [3:0]      funct3,
  output logic            funct7
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  logic [31:0]     skid_q, skid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            valid_q, valid_d;

  logic            redirect;
  logic            slot_free;
  logic [XLEN-1:0] target;

  assign redirect  = PCSource | flush;
  assign target    = PCTarget & ~XLEN'(3);
  assign slot_free = !valid_q || !stall;

  assign imemReq      = rst_n && (state_q == S_FETCH);
  assign imemAddr     = pc_q;
  assign instr        = instr_q;
  assign instrPC      = ipc_q;
  assign instrValid   = valid_q;
  assign instrPCPlus4 = ipc_q + XLEN'(4);
  assign OPCode       = instr_q[6:0];
  assign funct3       = {1'b0, instr_q[14:12]};
  assign funct7       = instr_q[30];

  // Next-state: fetch FSM, PC/redirect, kill tracking, skid and IF/ID.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    kill_d    = kill_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    valid_d   = valid_q && stall;
    if (redirect) begin
      pc_d    = target;
      valid_d = valid_q && stall && !flush;
    end
    unique case (state_q)
      S_FETCH: begin
        if (imemReady) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
          if (redirect) kill_d = 1'b1;
          else          pc_d   = pc_q + XLEN'(4);
        end
      end
      S_WAIT: begin
        if (imemRvalid) begin
          state_d = S_FETCH;
          if (kill_q || redirect) begin
            kill_d = 1'b0;
          end else if (slot_free) begin
            instr_d = imemRdata;
            ipc_d   = req_pc_q;
            valid_d = 1'b1;
          end else begin
            skid_d    = imemRdata;
            skid_pc_d = req_pc_q;
            state_d   = S_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_FETCH;
        end else if (slot_free) begin
          instr_d = skid_q;
          ipc_d   = skid_pc_q;
          valid_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State registers; async reset discards any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      kill_q    <= 1'b0;
      skid_q    <= NOP;
      skid_pc_q <= '0;
      instr_q   <= NOP;
      ipc_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      kill_q    <= kill_d;
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model, scoreboard monitor,
// directed scenarios for latency, stall/skid, redirects, wrap, reset.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        PCSource;
  logic [31:0] PCTarget;
  logic        stall;
  logic        flush;
  logic [31:0] instr;
  logic [31:0] instrPC;
  logic [31:0] instrPCPlus4;
  logic        instrValid;
  logic [6:0]  OPCode;
  logic [3:0]  funct3;
  logic        funct7;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  int          mem_lat = 1;
  logic        mem_rv  = 1'b0;
  logic [31:0] mem_data = '0;
  logic        man_rv  = 1'b0;
  logic [31:0] man_data = '0;

  assign imemRvalid = mem_rv | man_rv;
  assign imemRdata  = man_rv ? man_data : mem_data;

  instruction_fetch #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemReady   (imemReady),
    .imemRvalid  (imemRvalid),
    .imemRdata   (imemRdata),
    .PCSource    (PCSource),
    .PCTarget    (PCTarget),
    .stall       (stall),
    .flush       (flush),
    .instr       (instr),
    .instrPC     (instrPC),
    .instrPCPlus4(instrPCPlus4),
    .instrValid  (instrValid),
    .OPCode      (OPCode),
    .funct3      (funct3),
    .funct7      (funct7)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: latch acceptance mid-cycle, answer mem_lat cycles later.
  initial begin
    logic        pend;
    logic [31:0] pa;
    int          cnt;
    pend = 1'b0;
    pa   = '0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else if (imemReq && imemReady) begin
        pend = 1'b1;
        pa   = imemAddr;
        cnt  = mem_lat;
      end
      @(posedge clk);
      #1;
      mem_rv = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          mem_rv   = 1'b1;
          mem_data = mem_word(pa);
          pend     = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: each consumed IF/ID entry is popped and compared.
  initial begin
    logic [31:0] e;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (rst_n && instrValid && !stall && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected got_pc=%h exp=none", instrPC);
        end else begin
          e = exp_q.pop_front();
          d = mem_word(e);
          chk("sb_instr", instr, d);
          chk("sb_pc", instrPC, e);
          chk("sb_pc4", instrPCPlus4, e + 32'd4);
          chk("sb_decode", 32'({OPCode, funct3, funct7}),
              32'({d[6:0], 1'b0, d[14:12], d[30]}));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    imemReady = 1'b1;
    PCSource  = 1'b0;
    PCTarget  = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(imemReq), 32'd0);
    chk("rst_valid", 32'(instrValid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instrPC, 32'd0);
    chk("rst_pc4", instrPCPlus4, 32'd4);
    chk("rst_op", 32'(OPCode), 32'h13);
    chk("rst_f3", 32'(funct3), 32'd0);
    chk("rst_f7", 32'(funct7), 32'd0);
    chk("rst_addr", imemAddr, 32'd0);

    // Zero-wait streaming after reset release
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("addr0", imemAddr, 32'h0);
    chk("req0", 32'(imemReq), 32'd1);
    tick();
    chk("wait_req", 32'(imemReq), 32'd0);
    chk("lat_v1", 32'(instrValid), 32'd0);
    tick();
    chk("lat_v2", 32'(instrValid), 32'd1);
    chk("addr4", imemAddr, 32'h4);
    tick();
    tick();
    chk("addr8", imemAddr, 32'h8);
    tick();
    tick();

    // Memory not ready for 5 cycles
    imemReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("ws_req", 32'(imemReq), 32'd1);
      chk("ws_addr", imemAddr, 32'hC);
      tick();
    end

    // Stall for 3 cycles while a word returns
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    imemReady = 1'b1;
    tick();
    tick();
    stall = 1'b1;
    tick();
    chk("st_v", 32'(instrValid), 32'd1);
    chk("st_pc", instrPC, 32'hC);
    tick();
    chk("hold_req", 32'(imemReq), 32'd0);
    chk("st_instr", instr, mem_word(32'hC));
    chk("st_pc2", instrPC, 32'hC);
    tick();
    chk("hold_req2", 32'(imemReq), 32'd0);
    stall = 1'b0;
    tick();
    chk("sk_pc", instrPC, 32'h10);
    chk("sk_v", 32'(instrValid), 32'd1);
    chk("sk_addr", imemAddr, 32'h14);

    // Redirect while waiting on a slow response
    exp_q.push_back(32'h100);
    mem_lat = 3;
    tick();
    PCSource = 1'b1;
    PCTarget = 32'h0000_0103;
    tick();
    PCSource = 1'b0;
    chk("kill_req", 32'(imemReq), 32'd0);
    tick();
    tick();
    chk("rd_addr", imemAddr, 32'h100);
    chk("rd_req", 32'(imemReq), 32'd1);
    chk("rd_v", 32'(instrValid), 32'd0);
    mem_lat = 1;
    tick();
    tick();

    // Redirect in the same cycle the request is accepted
    exp_q.push_back(32'h200);
    PCSource = 1'b1;
    PCTarget = 32'h0000_0200;
    tick();
    PCSource = 1'b0;
    chk("sc_req", 32'(imemReq), 32'd0);
    tick();
    chk("sc_addr", imemAddr, 32'h200);
    chk("sc_v", 32'(instrValid), 32'd0);
    tick();
    tick();

    // Wrap-around at the top of the address space
    imemReady = 1'b0;
    PCSource  = 1'b1;
    PCTarget  = 32'hFFFF_FFFF;
    tick();
    PCSource  = 1'b0;
    imemReady = 1'b1;
    chk("wr_addr", imemAddr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("wr_pc", instrPC, 32'hFFFF_FFFC);
    chk("wr_pc4", instrPCPlus4, 32'h0);
    chk("wr_next", imemAddr, 32'h0);
    chk("wr_instr", instr, mem_word(32'hFFFF_FFFC));
    stall     = 1'b1;
    imemReady = 1'b0;

    // Flush beats stall
    tick();
    chk("fl_hold", 32'(instrValid), 32'd1);
    flush    = 1'b1;
    PCTarget = 32'h0000_0300;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    chk("fl_v", 32'(instrValid), 32'd0);
    chk("fl_addr", imemAddr, 32'h300);

    // Reset in the middle of a WAIT, then a stray late response
    mem_lat   = 50;
    imemReady = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_req", 32'(imemReq), 32'd0);
    chk("mr_v", 32'(instrValid), 32'd0);
    chk("mr_instr", instr, NOP);
    chk("mr_pc", instrPC, 32'd0);
    chk("mr_pc4", instrPCPlus4, 32'd4);
    chk("mr_addr", imemAddr, 32'd0);
    imemReady = 1'b0;
    tick();
    rst_n    = 1'b1;
    man_rv   = 1'b1;
    man_data = 32'h0040_0093;
    mem_lat  = 1;
    #1;
    chk("late_req", 32'(imemReq), 32'd1);
    chk("late_addr", imemAddr, 32'd0);
    tick();
    man_rv = 1'b0;
    chk("late_v", 32'(instrValid), 32'd0);
    chk("late_instr", instr, NOP);
    exp_q.push_back(32'h0);
    imemReady = 1'b1;
    tick();
    tick();
    imemReady = 1'b0;
    chk("final_v", 32'(instrValid), 32'd1);
    tick();
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage feeding the control unit and datapath of the RISC-V core. It holds the PC, issues single-outstanding requests to instruction memory over a request/ready + response-valid handshake, and captures each returned word in an IF/ID register. It decodes OPCode/funct3/funct7 for the control unit, and it applies PC redirects (PCSource/PCTarget) from the execute side with wrong-path kill.

## Interface
- XLEN, 32, PC and address width
- RESET_PC, 32'h0000_0000, first fetch address (must be 4-aligned)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imemReq  out  1  fetch request valid
- imemAddr  out  XLEN  fetch address (= pc)
- imemReady  in  1  memory accepts request this cycle
- imemRvalid  in  1  response word valid
- imemRdata  in  32  response word
- PCSource  in  1  redirect: next fetch from PCTarget
- PCTarget  in  XLEN  redirect target; bits [1:0] forced to 0
- stall  in  1  downstream holds IF/ID contents
- flush  in  1  invalidate IF/ID and any in-flight fetch
- instr  out  32  IF/ID instruction word
- instrPC  out  XLEN  address of instr
- instrPCPlus4  out  XLEN  instrPC + 4
- instrValid  out  1  IF/ID holds a live instruction
- OPCode  out  7  instr[6:0]
- funct3  out  4  {1'b0, instr[14:12]}
- funct7  out  1  instr[30]

## Operation
- Registers: pc, state, kill flag, skid buffer (word + PC), IF/ID (instr, instrPC, instrValid).
- Slot free = !instrValid or (instrValid and !stall); a valid, unstalled slot is consumed each cycle.
- redirect = PCSource or flush. On redirect, pc <= {PCTarget[XLEN-1:2],2'b00}, and IF/ID instrValid <= 0 unless stall=1 and flush=0.
- State FETCH: imemReq=1, imemAddr=pc.
  - If imemReady: reqPC <= pc, pc <= pc+4 (mod 2^XLEN), go to WAIT.
  - If imemReady and redirect coincide: request issued, kill <= 1, pc <= target.
- State WAIT: imemReq=0.
  - Redirect sets kill <= 1 and loads pc.
  - On imemRvalid: if kill (or redirect this cycle), discard, clear kill, go to FETCH.
  - Else if slot free: load IF/ID {imemRdata, reqPC, valid=1}, go to FETCH.
  - Else: write skid buffer, go to HOLD.
- State HOLD: imemReq=0.
  - Redirect drops the skid and goes to FETCH.
  - Else when slot free: move skid into IF/ID, go to FETCH.
- At most one outstanding request; imemRvalid outside WAIT is ignored.
- flush overrides stall: it clears instrValid unconditionally.

## Timing
- Reset (async, while rst_n=0):
  - pc=RESET_PC, state=FETCH, kill=0.
  - instr=32'h0000_0013 (NOP), instrPC=0, instrValid=0, imemReq=0.
- Outputs during reset: OPCode=7'h13, funct3=0, funct7=0, instrPCPlus4=4.
- First imemReq=1 in the first cycle after rst_n deasserts.
- Reset mid-transaction discards the in-flight response.
- Latency, zero-wait memory:
  - Acceptance in cycle A, imemRvalid earliest A+1.
  - instrValid=1 visible from A+2.
  - Throughput is 1 instruction per 2 cycles.
- instrPCPlus4 and the decoded fields are combinational from IF/ID; all other outputs are registered or driven directly from state.
- Redirect takes effect for the next request: the fetch after a redirect uses the target address in the following FETCH cycle.

## Test plan
- Reset release, RESET_PC=0, memory with imemReady=1 and 1-cycle response:
  - imemAddr sequence is 0, 4, 8.
  - instrValid rises 2 cycles after the first acceptance.
  - OPCode/funct3/funct7 match the loaded words.
- stall held 3 cycles with a response arriving:
  - Word enters the skid and state reaches HOLD.
  - IF/ID is unchanged.
  - On stall release the skid word appears next cycle with the correct instrPC; no word is lost or duplicated.
- PCSource=1 with PCTarget=32'h0000_0103 while in WAIT:
  - Returned word is discarded.
  - Next imemAddr=32'h0000_0100.
- Redirect in the same cycle as imemReady=1: kill is set, the response is dropped, and the target is fetched next.
- Wrap-around and memory wait states:
  - pc=32'hFFFF_FFFC fetch gives next imemAddr=0 and instrPCPlus4=0.
  - imemReady low for 5 cycles keeps imemReq/imemAddr stable.
- Reset asserted mid-WAIT: outputs return to their reset values immediately, and the late imemRvalid after release is ignored.
